// File: rtl/usb_pkg.sv
// Shared constants and FSM encoding for the USB FIFO link (read and write paths).
`timescale 1ns/1ps
package usb_pkg;

  localparam int unsigned ByteWidth      = 8;
  localparam int unsigned DefFifoDepth   = 16;
  localparam int unsigned DefSetupCycles = 2;
  localparam int unsigned DefPulseCycles = 4;
  localparam int unsigned DefHoldCycles  = 2;
  localparam int unsigned DefTxeHoldoff  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StSetup,
    StStrobe,
    StHold,
    StWait
  } usb_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_tx_writer_if.sv
// Producer stream, USB chip status and shared-bus signals of the transmit writer.
`timescale 1ns/1ps
interface usb_tx_writer_if
  import usb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
);
  logic [ByteWidth-1:0]          tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          txe_n_raw;
  logic                          bus_req;
  logic                          bus_gnt;
  logic [ByteWidth-1:0]          data_out;
  logic                          data_oe;
  logic                          wr_n;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  // Environment side: producers, USB chip and the read path's arbiter.
  modport master (
    output tx_data, tx_valid, txe_n_raw, bus_gnt,
    input  tx_ready, bus_req, data_out, data_oe, wr_n, fifo_count
  );

  // Writer side.
  modport slave (
    input  tx_data, tx_valid, txe_n_raw, bus_gnt,
    output tx_ready, bus_req, data_out, data_oe, wr_n, fifo_count
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with extra-bit wrapping pointers; occupancy is the pointer difference.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         rdata_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + (AddrW + 1)'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata_i;
  end

  always_comb begin
    rdata_o = mem_q[rd_ptr_q[AddrW-1:0]];
    count_o = wr_ptr_q - rd_ptr_q;
    full_o  = (count_o == (AddrW + 1)'(Depth));
    empty_o = (count_o == '0);
  end

endmodule

// File: rtl/usb_tx_writer.sv
// FT245-style USB transmit path: buffers bytes and strobes them onto the shared bus
// under a request/grant handshake with the read path.
`timescale 1ns/1ps
module usb_tx_writer
  import usb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = DefFifoDepth,
  parameter int unsigned SETUP_CYCLES = DefSetupCycles,
  parameter int unsigned PULSE_CYCLES = DefPulseCycles,
  parameter int unsigned HOLD_CYCLES  = DefHoldCycles,
  parameter int unsigned TXE_HOLDOFF  = DefTxeHoldoff
) (
  input logic              clk,
  input logic              reset,
  usb_tx_writer_if.slave   tx_if
);
  localparam int unsigned CntMax = max_u(max_u(SETUP_CYCLES, PULSE_CYCLES),
                                         max_u(HOLD_CYCLES, TXE_HOLDOFF));
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

  usb_state_e            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  bus_req_q, bus_req_d;
  logic [ByteWidth-1:0]  data_out_q, data_out_d;
  logic                  data_oe_q, data_oe_d;
  logic                  wr_n_q, wr_n_d;
  logic                  txe_meta_q, txe_n_s_q;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ByteWidth-1:0]  fifo_rdata;
  logic [CountW-1:0]     fifo_count;

  assign fifo_push = tx_if.tx_valid && !fifo_full;

  sync_fifo #(
    .Width (ByteWidth),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wdata_i (tx_if.tx_data),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reset to "chip not ready" so nothing is requested before the first real sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      txe_meta_q <= 1'b1;
      txe_n_s_q  <= 1'b1;
    end else begin
      txe_meta_q <= tx_if.txe_n_raw;
      txe_n_s_q  <= txe_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bus_req_d  = bus_req_q;
    data_out_d = data_out_q;
    data_oe_d  = data_oe_q;
    wr_n_d     = wr_n_q;
    fifo_pop   = 1'b0;

    case (state_q)
      StIdle: begin
        if (!fifo_empty && !txe_n_s_q) begin
          state_d   = StReq;
          bus_req_d = 1'b1;
        end
      end
      StReq: begin
        if (txe_n_s_q) begin
          state_d   = StIdle;
          bus_req_d = 1'b0;
        end else if (tx_if.bus_gnt) begin
          state_d    = StSetup;
          data_out_d = fifo_rdata;
          data_oe_d  = 1'b1;
          fifo_pop   = 1'b1;
          cnt_d      = CntW'(SETUP_CYCLES - 1);
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StStrobe;
          wr_n_d  = 1'b0;
          cnt_d   = CntW'(PULSE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStrobe: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          wr_n_d  = 1'b1;
          cnt_d   = CntW'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d   = StWait;
          data_oe_d = 1'b0;
          cnt_d     = CntW'(TXE_HOLDOFF - 1);
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StWait: begin
        // txe_n from the chip is unreliable right after a strobe, so only look at the end.
        if (cnt_q == '0) begin
          if (!fifo_empty && !txe_n_s_q) begin
            state_d    = StSetup;
            data_out_d = fifo_rdata;
            data_oe_d  = 1'b1;
            fifo_pop   = 1'b1;
            cnt_d      = CntW'(SETUP_CYCLES - 1);
          end else begin
            state_d   = StIdle;
            bus_req_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d   = StIdle;
        bus_req_d = 1'b0;
        data_oe_d = 1'b0;
        wr_n_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bus_req_q  <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      wr_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bus_req_q  <= bus_req_d;
      data_out_q <= data_out_d;
      data_oe_q  <= data_oe_d;
      wr_n_q     <= wr_n_d;
    end
  end

  assign tx_if.tx_ready   = !fifo_full;
  assign tx_if.bus_req    = bus_req_q;
  assign tx_if.data_out   = data_out_q;
  assign tx_if.data_oe    = data_oe_q;
  assign tx_if.wr_n       = wr_n_q;
  assign tx_if.fifo_count = fifo_count;

endmodule

// File: tb/tb_usb_tx_writer.sv
// Directed bench for usb_tx_writer: bus monitor, lagging grant model and byte scoreboard.
`timescale 1ns/1ps
module tb_usb_tx_writer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  usb_tx_writer_if #(.FIFO_DEPTH(16)) tif ();

  usb_tx_writer #(
    .FIFO_DEPTH   (16),
    .SETUP_CYCLES (2),
    .PULSE_CYCLES (4),
    .HOLD_CYCLES  (2),
    .TXE_HOLDOFF  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .tx_if (tif)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] strobe_q[$];
  int         strobe_cyc[$];
  int         cyc = 0;
  int         accept_cyc = 0;
  int         low_run, oe_run, last_low, last_oe;
  int         req_rises, req_fall_cyc, no_oe_strobes, unstable;
  int         occ_min, occ_max;
  bit         track_occ = 1'b0;
  bit         wr_prev, req_prev, oe_prev;
  logic [7:0] dout_prev;
  bit         gnt_en = 1'b1;
  bit         gnt_next = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Read path model: grant follows bus_req one cycle late, so it never drops while requested.
  always @(negedge clk) gnt_next = tif.bus_req && gnt_en;
  always @(posedge clk) begin
    #1;
    tif.bus_gnt = gnt_next;
  end

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      strobe_q.delete();
      strobe_cyc.delete();
      low_run = 0; oe_run = 0; last_low = 0; last_oe = 0;
      req_rises = 0; req_fall_cyc = 0; no_oe_strobes = 0; unstable = 0;
      wr_prev = 1'b1; req_prev = 1'b0; oe_prev = 1'b0; dout_prev = 8'h00;
    end else begin
      if (wr_prev && !tif.wr_n) begin
        strobe_q.push_back(tif.data_out);
        strobe_cyc.push_back(cyc);
        if (!tif.data_oe) no_oe_strobes++;
      end
      if (!tif.wr_n) low_run++;
      else if (low_run != 0) begin last_low = low_run; low_run = 0; end
      if (tif.data_oe) oe_run++;
      else if (oe_run != 0) begin last_oe = oe_run; oe_run = 0; end
      if (oe_prev && tif.data_oe && tif.data_out != dout_prev) unstable++;
      if (!req_prev && tif.bus_req) req_rises++;
      if (req_prev && !tif.bus_req) req_fall_cyc = cyc;
      if (track_occ) begin
        if (int'(tif.fifo_count) < occ_min) occ_min = int'(tif.fifo_count);
        if (int'(tif.fifo_count) > occ_max) occ_max = int'(tif.fifo_count);
      end
      wr_prev = tif.wr_n; req_prev = tif.bus_req; oe_prev = tif.data_oe;
      dout_prev = tif.data_out;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(1);
    reset = 1'b1;
    tif.tx_valid = 1'b0;
    tick(2);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int n = 0;
    tif.tx_data  = b;
    tif.tx_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = tif.tx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    tif.tx_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(b);
      accept_cyc = cyc;
    end else begin
      check_eq("push_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_strobes(input int n, input int bound, input string tag);
    int i = 0;
    while (strobe_q.size() < n && i < bound) begin tick(1); i++; end
    if (strobe_q.size() < n) check_eq(tag, strobe_q.size(), n);
  endtask

  task automatic wait_req(input logic level, input int bound, input string tag);
    int i = 0;
    while (tif.bus_req !== level && i < bound) begin tick(1); i++; end
    if (tif.bus_req !== level) check_eq(tag, tif.bus_req, level);
  endtask

  task automatic compare_sb(input string tag);
    check_eq({tag, "_count"}, strobe_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < strobe_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), strobe_q[i], exp_q[i]);
  endtask

  initial begin
    int bad_req, bad_oe, bad_wr;
    tif.tx_data   = 8'h00;
    tif.tx_valid  = 1'b0;
    tif.txe_n_raw = 1'b1;
    tif.bus_gnt   = 1'b0;

    // Reset state
    do_reset();
    @(negedge clk);
    check_eq("rst_wr_n", tif.wr_n, 1);
    check_eq("rst_data_oe", tif.data_oe, 0);
    check_eq("rst_data_out", tif.data_out, 8'h00);
    check_eq("rst_bus_req", tif.bus_req, 0);
    check_eq("rst_tx_ready", tif.tx_ready, 1);
    check_eq("rst_fifo_count", tif.fifo_count, 0);

    // Single byte
    tick(1);
    tif.txe_n_raw = 1'b0;
    tick(3);
    push_byte(8'hA5);
    wait_strobes(1, 40, "single_strobe_timeout");
    wait_req(1'b0, 40, "single_req_drop_timeout");
    tick(2);
    compare_sb("single");
    if (strobe_cyc.size() > 0) begin
      check_eq("single_latency", strobe_cyc[0] - accept_cyc, 4 + 2);
      check_eq("single_req_fall", req_fall_cyc - strobe_cyc[0], 4 + 2 + 4);
    end
    check_eq("single_wr_low_len", last_low, 4);
    check_eq("single_oe_len", last_oe, 8);
    check_eq("single_req_rises", req_rises, 1);
    check_eq("single_oe_at_strobe", no_oe_strobes, 0);

    // Fill and burst
    do_reset();
    tif.txe_n_raw = 1'b1;
    tick(3);
    for (int i = 0; i < 16; i++) push_byte(8'(i));
    @(negedge clk);
    check_eq("fill_tx_ready", tif.tx_ready, 0);
    check_eq("fill_count", tif.fifo_count, 16);
    tick(5);
    check_eq("fill_no_strobe", strobe_q.size(), 0);
    tif.txe_n_raw = 1'b0;
    wait_strobes(16, 400, "burst_timeout");
    wait_req(1'b0, 40, "burst_req_drop_timeout");
    tick(2);
    compare_sb("burst");
    for (int i = 1; i < strobe_cyc.size(); i++)
      check_eq($sformatf("burst_gap%0d", i), strobe_cyc[i] - strobe_cyc[i-1], 12);
    check_eq("burst_req_rises", req_rises, 1);
    check_eq("burst_data_stable", unstable, 0);

    // Flow control
    do_reset();
    tif.txe_n_raw = 1'b1;
    tick(3);
    for (int i = 0; i < 5; i++) push_byte(8'(i));
    tif.txe_n_raw = 1'b0;
    wait_strobes(3, 200, "flow_strobe3_timeout");
    for (int i = 0; i < 20 && !tif.wr_n; i++) @(negedge clk);
    tif.txe_n_raw = 1'b1;
    tick(1);
    wait_req(1'b0, 40, "flow_idle_timeout");
    @(negedge clk);
    check_eq("flow_count_idle", tif.fifo_count, 2);
    tick(30);
    check_eq("flow_strobes_paused", strobe_q.size(), 3);
    check_eq("flow_req_paused", tif.bus_req, 0);
    tif.txe_n_raw = 1'b0;
    wait_strobes(5, 200, "flow_resume_timeout");
    wait_req(1'b0, 40, "flow_req_drop_timeout");
    compare_sb("flow");
    check_eq("flow_req_rises", req_rises, 2);

    // Grant delay
    do_reset();
    tif.txe_n_raw = 1'b0;
    gnt_en = 1'b0;
    tick(3);
    push_byte(8'h5A);
    wait_req(1'b1, 10, "gnt_req_timeout");
    bad_req = 0; bad_oe = 0; bad_wr = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tif.bus_req !== 1'b1) bad_req++;
      if (tif.data_oe !== 1'b0) bad_oe++;
      if (tif.wr_n !== 1'b1) bad_wr++;
    end
    check_eq("gnt_wait_bus_req", bad_req, 0);
    check_eq("gnt_wait_data_oe", bad_oe, 0);
    check_eq("gnt_wait_wr_n", bad_wr, 0);
    tick(1);
    gnt_en = 1'b1;
    wait_strobes(1, 40, "gnt_strobe_timeout");
    wait_req(1'b0, 40, "gnt_req_drop_timeout");
    compare_sb("gnt");

    // Reset mid-strobe
    do_reset();
    tif.txe_n_raw = 1'b0;
    tick(3);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    begin
      int i = 0;
      @(negedge clk);
      while (tif.wr_n && i < 40) begin @(negedge clk); i++; end
      check_eq("rstmid_reached_strobe", tif.wr_n, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    check_eq("rstmid_wr_n", tif.wr_n, 1);
    check_eq("rstmid_data_oe", tif.data_oe, 0);
    check_eq("rstmid_fifo_count", tif.fifo_count, 0);
    check_eq("rstmid_tx_ready", tif.tx_ready, 1);
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    tick(30);
    check_eq("rstmid_no_strobe", strobe_q.size(), 0);

    // Streaming into a full FIFO
    do_reset();
    tif.txe_n_raw = 1'b1;
    tick(3);
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    occ_min = 99;
    occ_max = 0;
    track_occ = 1'b1;
    tif.txe_n_raw = 1'b0;
    for (int i = 0; i < 8; i++) push_byte(8'h80 + 8'(i));
    track_occ = 1'b0;
    wait_strobes(24, 700, "full_stream_timeout");
    wait_req(1'b0, 40, "full_req_drop_timeout");
    check_eq("full_occ_min", occ_min, 15);
    check_eq("full_occ_max", occ_max, 16);
    compare_sb("full");
    check_eq("full_req_rises", req_rises, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x1, expected 0x0");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/usb_tx_writer.md
# usb_tx_writer

Transmit side of the FT245-style USB FIFO link between the cube controller FPGA and the host PC. Accepts bytes from internal producers such as panel-switch status and acknowledgements, and buffers them in a small FIFO. Writes them to the USB chip over the shared 8-bit data bus using `txe_n` flow control and `wr_n` strobes. Sits beside the existing USB read path in `usb_controller` and shares the bus under an explicit request/grant handshake.

## Interface
- `FIFO_DEPTH`, 16: byte buffer depth; power of two, at least 2.
- `SETUP_CYCLES`, 2: cycles data is driven before `wr_n` falls; at least 1.
- `PULSE_CYCLES`, 4: `wr_n` low width in cycles; at least 1.
- `HOLD_CYCLES`, 2: cycles data stays driven after `wr_n` rises; at least 1.
- `TXE_HOLDOFF`, 4: cycles after a write during which synced `txe_n` is ignored; at least 3.
- `clk`, in, 1: 50 MHz system clock.
- `reset`, in, 1: synchronous, active-high reset.
- `tx_data`, in, 8: byte to send.
- `tx_valid`, in, 1: `tx_data` is valid.
- `tx_ready`, out, 1: FIFO not full; a byte is accepted when `tx_valid && tx_ready`.
- `txe_n_raw`, in, 1: asynchronous USB chip status; low means the chip can accept a byte.
- `bus_req`, out, 1: request ownership of the data bus.
- `bus_gnt`, in, 1: read path grants the bus; it is held until `bus_req` drops.
- `data_out`, out, 8: value driven onto the bus.
- `data_oe`, out, 1: tristate enable for `data_out`.
- `wr_n`, out, 1: USB write strobe, active low.
- `fifo_count`, out, clog2(`FIFO_DEPTH`)+1: current FIFO occupancy.

## Operation
- `txe_n_raw` passes through a 2-flop synchronizer, giving `txe_n_s`. The synchronizer resets to 1 (chip not ready).
- FIFO behaviour:
  - Synchronous, with read and write pointers one bit wider than the address, wrapping naturally.
  - A push and a pop in the same cycle leave `fifo_count` unchanged. This is legal when full, but `tx_ready` is still low when full, so no push happens.
  - A push when full is impossible by handshake.
  - A pop happens only in the FSM and never when empty.
- FSM states:
  - IDLE: `bus_req` is 0. Go to REQ when the FIFO is not empty and `txe_n_s` is 0.
  - REQ: `bus_req` is 1. On `bus_gnt` go to SETUP. Load the head byte into `data_out`, pop the FIFO, and set `data_oe` to 1.
  - SETUP: wait `SETUP_CYCLES`, then go to STROBE.
  - STROBE: `wr_n` is 0 for `PULSE_CYCLES`, then go to HOLD.
  - HOLD: `wr_n` is 1 and data is still driven for `HOLD_CYCLES`. Then `data_oe` goes to 0 and the FSM goes to WAIT.
  - WAIT: `bus_req` stays 1 for `TXE_HOLDOFF` cycles. Then:
    - If the FIFO is not empty and `txe_n_s` is 0, go to SETUP with the next byte. This is a burst without releasing the bus.
    - Otherwise drop `bus_req` and go to IDLE.
- If `txe_n_s` rises during REQ, the FSM returns to IDLE and drops `bus_req`. Nothing is popped.
- A byte that has been popped is always completed, even if `txe_n_s` changes or `bus_gnt` drops mid-write. The read path must never revoke the grant while `bus_req` is 1.
- A single down-counter, sized to the largest parameter, times SETUP, STROBE, HOLD and WAIT.

## Timing
- Reset values:
  - `wr_n` = 1, `data_oe` = 0, `data_out` = 0x00, `bus_req` = 0.
  - `tx_ready` = 1, `fifo_count` = 0, FSM in IDLE, synchronizer = 1.
- Reset asserted mid-write takes effect on the next edge. `wr_n` goes high and `data_oe` goes low immediately, and the FIFO contents are discarded.
- `wr_n`, `data_oe` and `data_out` are registered outputs.
- `tx_ready` is combinational from `fifo_count`.
- Minimum latency from the first push into an empty FIFO (with `txe_n_s` already 0 and `bus_gnt` returned the cycle after `bus_req`) to `wr_n` falling is 4 + `SETUP_CYCLES` cycles.
- Byte period in a burst is `SETUP_CYCLES` + `PULSE_CYCLES` + `HOLD_CYCLES` + `TXE_HOLDOFF` cycles. This is 12 cycles, or 240 ns, with the defaults.
- `data_out` is stable for the whole time `data_oe` is 1.

## Structure
- A shared `usb_pkg` holds:
  - the FSM state encoding (IDLE, REQ, SETUP, STROBE, HOLD, WAIT);
  - the default timing constants;
  - the byte width constant. The `usb_controller` read path uses the same constants.
- One sub-module, `sync_fifo`, parameterised by width and depth, provides the push/pop/count interface. The synchronizer and FSM live in `usb_tx_writer`.

## Test plan
- **Single byte:** after reset, hold `txe_n_raw` at 0 and `bus_gnt` at 1 one cycle after `bus_req`, then push 0xA5.
  - `wr_n` is low for exactly 4 cycles with `data_out` = 0xA5.
  - `data_oe` is 1 for 8 cycles in total.
  - `bus_req` drops after WAIT.
- **Fill and burst:** push 16 bytes 0x00 to 0x0F with `txe_n_raw` at 1.
  - `tx_ready` goes to 0 and `fifo_count` reads 16.
  - Then release `txe_n_raw` to 0. The 16 strobes occur in order, 12 cycles apart, under a single `bus_req` assertion.
- **Flow control:** raise `txe_n_raw` after the 3rd strobe of a 5-byte burst.
  - The FSM idles after WAIT with `fifo_count` = 2.
  - Lowering `txe_n_raw` sends 0x03 and 0x04.
- **Grant delay:** hold `bus_gnt` at 0 for 20 cycles.
  - `bus_req` stays 1, `data_oe` stays 0 and `wr_n` stays 1.
  - The write proceeds once `bus_gnt` is 1.
- **Reset mid-strobe:** assert `reset` during STROBE.
  - The next cycle shows `wr_n` = 1, `data_oe` = 0, `fifo_count` = 0 and `tx_ready` = 1.
- **Simultaneous push and pop at full:** occupancy stays at 15 or 16 as expected, and no byte is lost or duplicated. Check the full sequence against a scoreboard.
